// File: rtl/inert_pkg.sv
// Shared types and SPI command words for the inertial sensor front end.
package inert_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT, CFG0, CFG1, CFG2, CFG3, IDLE,
    RD_PL, RD_PH, RD_AL, RD_AH, VLD
  } state_t;

  localparam logic [15:0] CMD_CFG0  = 16'h0D02;  // INT on data-ready
  localparam logic [15:0] CMD_CFG1  = 16'h1053;  // accel ODR
  localparam logic [15:0] CMD_CFG2  = 16'h1150;  // gyro ODR
  localparam logic [15:0] CMD_CFG3  = 16'h1460;  // rounding
  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

  function automatic logic is_cmd(input state_t s);
    return s inside {CFG0, CFG1, CFG2, CFG3, RD_PL, RD_PH, RD_AL, RD_AH};
  endfunction

  function automatic logic [15:0] state_cmd(input state_t s);
    case (s)
      CFG0:    return CMD_CFG0;
      CFG1:    return CMD_CFG1;
      CFG2:    return CMD_CFG2;
      CFG3:    return CMD_CFG3;
      RD_PL:   return CMD_RD_PL;
      RD_PH:   return CMD_RD_PH;
      RD_AL:   return CMD_RD_AL;
      RD_AH:   return CMD_RD_AH;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/inert_intf_int_sync.sv
// Two-flop synchronizer for the sensor interrupt, plus a registered rising-edge pulse.
module int_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sff;

  always_ff @(posedge clk) begin
    if (rst) begin
      sff  <= 3'b000;
      rise <= 1'b0;
    end else begin
      sff  <= {sff[1:0], async_in};
      rise <= sff[1] & ~sff[2];
    end
  end

endmodule

// File: rtl/inert_intf.sv
// Sequences the 6-axis sensor over SPI: power-up wait, config writes, then
// a four-byte read per data-ready interrupt, presenting pitch rate and AZ.
module inert_intf
  import inert_pkg::*;
#(
  parameter int INIT_TMR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        rdy,
  output logic        vld,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ
);

  state_t                state, nxt;
  logic [INIT_TMR_W-1:0] timer;
  logic                  pending;
  logic                  int_rise;
  logic                  enter_cmd;
  logic [7:0]            pl, ph, al;
  logic                  unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];

  int_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (INT),
    .rise     (int_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_WAIT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      INIT_WAIT: if (&timer) nxt = CFG0;
      CFG0:      if (done) nxt = CFG1;
      CFG1:      if (done) nxt = CFG2;
      CFG2:      if (done) nxt = CFG3;
      CFG3:      if (done) nxt = IDLE;
      IDLE:      if (int_rise) nxt = RD_PL;
      RD_PL:     if (done) nxt = RD_PH;
      RD_PH:     if (done) nxt = RD_AL;
      RD_AL:     if (done) nxt = RD_AH;
      RD_AH:     if (done) nxt = VLD;
      // an edge landing in the VLD cycle itself must not be lost
      VLD:       nxt = (pending || int_rise) ? RD_PL : IDLE;
      default:   nxt = INIT_WAIT;
    endcase
  end

  assign enter_cmd = is_cmd(nxt) && (nxt != state);

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      wrt     <= 1'b0;
      cmd     <= 16'h0000;
      rdy     <= 1'b0;
      vld     <= 1'b0;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
      pending <= 1'b0;
      pl      <= 8'h00;
      ph      <= 8'h00;
      al      <= 8'h00;
    end else begin
      if (state == INIT_WAIT && !(&timer))
        timer <= timer + {{(INIT_TMR_W-1){1'b0}}, 1'b1};
      wrt <= enter_cmd;
      if (enter_cmd) cmd <= state_cmd(nxt);
      vld <= (nxt == VLD);
      if (state == CFG3 && done) rdy <= 1'b1;

      if (state == VLD)
        pending <= 1'b0;
      else if (int_rise && rdy && state != IDLE)
        pending <= 1'b1;

      if (done) begin
        case (state)
          RD_PL: pl <= rd_data[7:0];
          RD_PH: ph <= rd_data[7:0];
          RD_AL: al <= rd_data[7:0];
          // AH goes straight to the output so both words land with vld
          RD_AH: begin
            ptch_rt <= {ph, pl};
            AZ      <= {rd_data[7:0], al};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inert_intf.sv
// Directed bench for inert_intf with a fixed-latency SPI responder model.
module tb_inert_intf;

  logic        clk = 1'b0;
  logic        rst, INT, done;
  logic [15:0] rd_data;
  logic        wrt, rdy, vld;
  logic [15:0] cmd, ptch_rt, AZ;

  inert_intf #(.INIT_TMR_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .INT     (INT),
    .done    (done),
    .rd_data (rd_data),
    .wrt     (wrt),
    .cmd     (cmd),
    .rdy     (rdy),
    .vld     (vld),
    .ptch_rt (ptch_rt),
    .AZ      (AZ)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int errs = 0;
  int nchk = 0;
  int vld_dbl = 0;
  int stab_err = 0;
  bit abort_ok = 0;

  logic [15:0] cmd_q[$];
  int          wrt_cyc_q[$];
  logic [7:0]  rd_bytes[$];
  logic [15:0] vp_q[$], va_q[$], prev_p_q[$];
  int          vcyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SPI responder: done 8 clocks after each wrt, returns queued bytes
  initial begin
    logic [15:0] cur;
    done = 1'b0;
    rd_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      done = 1'b0;
      if (wrt) begin
        cur = cmd;
        cmd_q.push_back(cmd);
        wrt_cyc_q.push_back(cyc);
        repeat (8) begin
          @(posedge clk); #1;
          if (!abort_ok && (cmd !== cur || wrt)) stab_err++;
        end
        done = 1'b1;
        rd_data = (rd_bytes.size() > 0) ? {8'hEE, rd_bytes.pop_front()} : 16'h0000;
      end
    end
  end

  // vld monitor: records each pulse and the ptch_rt value just before it
  initial begin
    logic        pv;
    logic [15:0] pp;
    pv = 1'b0;
    pp = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (vld) begin
        if (pv) vld_dbl++;
        vp_q.push_back(ptch_rt);
        va_q.push_back(AZ);
        vcyc_q.push_back(cyc);
        prev_p_q.push_back(pp);
      end
      pv = vld;
      pp = ptch_rt;
    end
  end

  task automatic run_int(input int nv, input string tag);
    int  c0;
    bit  to;
    c0 = cyc;
    INT = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (cyc == c0 + 2) INT = 1'b0;
      if (vcyc_q.size() >= nv) begin
        to = 1'b0;
        break;
      end
    end
    INT = 1'b0;
    chk(tag, {31'd0, to}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  logic [15:0] cfg_cmds[4];
  logic [15:0] rd_cmds[4];

  initial begin
    int  rel, rdy_c, int_c, c0, p, base, nv, tgt;
    bit  to;
    cfg_cmds = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    rd_cmds  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    rst = 1'b1;
    INT = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_ctl", {29'd0, wrt, rdy, vld}, 32'd0);
    chk("rst_data", {ptch_rt, AZ}, 32'd0);
    rst = 1'b0;
    rel = cyc;

    // power-up; an INT edge during CFG1 must be discarded
    to = 1'b1;
    int_c = -1;
    rdy_c = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cmd_q.size() == 2 && int_c < 0) begin
        INT = 1'b1;
        int_c = cyc;
      end
      if (int_c >= 0 && cyc == int_c + 3) INT = 1'b0;
      if (rdy) begin
        to = 1'b0;
        rdy_c = cyc;
        break;
      end
    end
    INT = 1'b0;
    chk("pwr_timeout", {31'd0, to}, 32'd0);
    chk("cfg_count", cmd_q.size(), 32'd4);
    chk("first_wrt_clk", wrt_cyc_q[0] - rel + 1, 32'd17);
    for (int i = 0; i < 4; i++) chk($sformatf("cfg_cmd%0d", i), {16'd0, cmd_q[i]}, {16'd0, cfg_cmds[i]});
    chk("rdy_rise", rdy_c - wrt_cyc_q[3], 32'd9);
    repeat (30) @(posedge clk);
    #1;
    chk("cfg_int_ignored", cmd_q.size(), 32'd4);
    chk("pwr_no_vld", vcyc_q.size(), 32'd0);

    // single read
    cmd_q.delete();
    wrt_cyc_q.delete();
    rd_bytes = '{8'h50, 8'h10, 8'h00, 8'h08};
    c0 = cyc;
    run_int(1, "rd1_timeout");
    chk("rd1_lat", wrt_cyc_q[0] - c0, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rd1_cmd%0d", i), {16'd0, cmd_q[i]}, {16'd0, rd_cmds[i]});
    chk("rd1_vld_clk", vcyc_q[0] - wrt_cyc_q[0], 32'd36);
    chk("rd1_ptch", {16'd0, vp_q[0]}, 32'h1050);
    chk("rd1_az", {16'd0, va_q[0]}, 32'h0800);

    // negative values, previous ones held until vld
    cmd_q.delete();
    wrt_cyc_q.delete();
    rd_bytes = '{8'h50, 8'hF0, 8'h00, 8'hF8};
    chk("hold_az", {16'd0, AZ}, 32'h0800);
    run_int(2, "rd2_timeout");
    chk("hold_ptch", {16'd0, prev_p_q[1]}, 32'h1050);
    chk("rd2_ptch", {16'd0, vp_q[1]}, 32'hF050);
    chk("rd2_az", {16'd0, va_q[1]}, 32'hF800);

    // two edges during RD_PH collapse into one back-to-back sequence
    cmd_q.delete();
    wrt_cyc_q.delete();
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    base = vcyc_q.size();
    c0 = cyc;
    p = -1;
    to = 1'b1;
    INT = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cyc == c0 + 2) INT = 1'b0;
      if (cmd_q.size() == 2 && p < 0) p = cyc;
      if (p >= 0 && (cyc == p + 1 || cyc == p + 5)) INT = 1'b1;
      if (p >= 0 && (cyc == p + 3 || cyc == p + 7)) INT = 1'b0;
      if (vcyc_q.size() >= base + 2) begin
        to = 1'b0;
        break;
      end
    end
    INT = 1'b0;
    chk("dbl_timeout", {31'd0, to}, 32'd0);
    repeat (60) @(posedge clk);
    #1;
    chk("dbl_vld_count", vcyc_q.size() - base, 32'd2);
    chk("dbl_cmd_count", cmd_q.size(), 32'd8);
    chk("dbl_back2back", wrt_cyc_q[4] - vcyc_q[base], 32'd1);
    chk("dbl_ptch0", {vp_q[base], va_q[base]}, 32'h2211_4433);
    chk("dbl_ptch1", {vp_q[base+1], va_q[base+1]}, 32'h6655_8877);

    // reset in RD_AL, done arrives the following cycle
    cmd_q.delete();
    wrt_cyc_q.delete();
    rd_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    nv = vcyc_q.size();
    abort_ok = 1'b1;
    c0 = cyc;
    to = 1'b1;
    INT = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cyc == c0 + 2) INT = 1'b0;
      if (cmd_q.size() >= 3) begin
        to = 1'b0;
        break;
      end
    end
    INT = 1'b0;
    chk("rst_al_timeout", {31'd0, to}, 32'd0);
    tgt = to ? cyc : wrt_cyc_q[2] + 7;
    while (cyc < tgt) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    chk("mid_rst_cmd", {16'd0, cmd}, 32'd0);
    chk("mid_rst_ctl", {29'd0, wrt, rdy, vld}, 32'd0);
    chk("mid_rst_data", {ptch_rt, AZ}, 32'd0);
    to = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 3) abort_ok = 1'b0;
      if (cmd_q.size() >= 4) begin
        to = 1'b0;
        break;
      end
    end
    chk("restart_timeout", {31'd0, to}, 32'd0);
    chk("restart_cmd", {16'd0, cmd_q[3]}, 32'h0D02);
    chk("restart_wrt_clk", wrt_cyc_q[3] - rel + 1, 32'd17);
    chk("mid_rst_no_vld", vcyc_q.size() - nv, 32'd0);

    chk("vld_double", vld_dbl, 32'd0);
    chk("cmd_stable", stab_err, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
